// File: rtl/jump_target_shift.sv
// Purpose : builds the absolute J-type jump target {PC[31:28], instr[25:0], 2'b00}.
// Latency : Out is combinational (0 cycles); tgt/tgt_valid follow an accept by 1 cycle.
// Backpr. : single-entry output register; in_ready drops while tgt_valid & ~tgt_ready.
//
// Ports
//   clk, rst        system clock; asynchronous active-high reset
//   Adr             instruction address field instr[25:0]
//   Adr_Rmdr        upper PC nibble PC+4[31:28]
//   in_valid/ready  input handshake (accept = in_valid & in_ready)
//   Out             combinational target, independent of clock, reset and handshake
//   tgt/tgt_valid   registered target, consumed by tgt_ready
//   jump_cnt        saturating count of accepted targets since reset
//   misalign_err    (only with JUMP_SHIFT_ALIGN_CHECK_EN) accepted jump changed the
//                   256 MB region relative to the previously accepted target
//
// Optional feature macro: JUMP_SHIFT_ALIGN_CHECK_EN
// CNT_W must be at least 4.

module jump_target_shift #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [25:0]      Adr,
    input  logic [3:0]       Adr_Rmdr,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      Out,
    output logic [31:0]      tgt,
    output logic             tgt_valid,
    input  logic             tgt_ready,
`ifdef JUMP_SHIFT_ALIGN_CHECK_EN
    output logic             misalign_err,
`endif
    output logic [CNT_W-1:0] jump_cnt
);

    logic [31:0]      tgt_q;
    logic             tgt_valid_q;
    logic [CNT_W-1:0] jump_cnt_q;
    logic             accept;
    logic             cnt_sat;

    // Pure bit placement: no carry and no sign extension ever reach the target.
    assign Out = {Adr_Rmdr, Adr, 2'b00};

    // The entry can take a new target if it is empty or being drained this cycle,
    // which gives one target per cycle when downstream keeps tgt_ready high.
    assign in_ready = ~tgt_valid_q | tgt_ready;
    assign accept   = in_valid & in_ready;
    assign cnt_sat  = &jump_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt_q       <= 32'h0;
            tgt_valid_q <= 1'b0;
        end else if (accept) begin
            tgt_q       <= Out;
            tgt_valid_q <= 1'b1;
        end else if (tgt_valid_q && tgt_ready) begin
            // Consumed with nothing behind it: tgt keeps its last value.
            tgt_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            jump_cnt_q <= '0;
        end else if (accept && !cnt_sat) begin
            jump_cnt_q <= jump_cnt_q + CNT_W'(1);
        end
    end

`ifdef JUMP_SHIFT_ALIGN_CHECK_EN
    // tgt_q always holds the last accepted target (it is never cleared by a
    // consume), so its top nibble is the previous region. seen_q suppresses the
    // comparison against the reset value of tgt_q on the first accept.
    logic seen_q;
    logic misalign_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else if (accept) begin
            seen_q     <= 1'b1;
            misalign_q <= seen_q && (Adr_Rmdr != tgt_q[31:28]);
        end
    end

    assign misalign_err = misalign_q;
`endif

    assign tgt       = tgt_q;
    assign tgt_valid = tgt_valid_q;
    assign jump_cnt  = jump_cnt_q;

endmodule

// File: tb/tb_jump_target_shift.sv
// Purpose : directed self-checking bench for jump_target_shift (CNT_W = 4).
// Latency : checks Out with no edge, tgt one cycle after each accept.
// Backpr. : exercises stall (tgt_ready=0), back-to-back and drain cases.

module tb_jump_target_shift;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [25:0]      Adr;
    logic [3:0]       Adr_Rmdr;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      Out;
    logic [31:0]      tgt;
    logic             tgt_valid;
    logic             tgt_ready;
    logic [CNT_W-1:0] jump_cnt;
`ifdef JUMP_SHIFT_ALIGN_CHECK_EN
    logic             misalign_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    jump_target_shift #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .Adr       (Adr),
        .Adr_Rmdr  (Adr_Rmdr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Out       (Out),
        .tgt       (tgt),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
`ifdef JUMP_SHIFT_ALIGN_CHECK_EN
        .misalign_err (misalign_err),
`endif
        .jump_cnt  (jump_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle past it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [25:0] adr;
        logic [3:0]  rm;
        logic [31:0] exp;
    } vec_t;

    vec_t comb_v[4];
    vec_t b2b_v[3];
    int   exp_cnt;

    initial begin
        comb_v[0] = '{26'h0000000, 4'h0, 32'h00000000};
        comb_v[1] = '{26'h3FFFFFF, 4'hF, 32'hFFFFFFFC};
        comb_v[2] = '{26'h0000001, 4'h1, 32'h10000004};
        comb_v[3] = '{26'h2AAAAAA, 4'h5, 32'h5AAAAAA8};
        b2b_v[0]  = '{26'h0000100, 4'h2, 32'h20000400};
        b2b_v[1]  = '{26'h0000200, 4'h2, 32'h20000800};
        b2b_v[2]  = '{26'h0000300, 4'h2, 32'h20000C00};

        rst       = 1'b1;
        Adr       = '0;
        Adr_Rmdr  = '0;
        in_valid  = 1'b0;
        tgt_ready = 1'b0;
        #2;

        // Reset state
        check("rst_tgt", tgt, 32'h0);
        check("rst_tgt_valid", 32'(tgt_valid), 32'h0);
        check("rst_jump_cnt", 32'(jump_cnt), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
`ifdef JUMP_SHIFT_ALIGN_CHECK_EN
        check("rst_misalign", 32'(misalign_err), 32'h0);
`endif

        // Combinational target, sampled between edges
        for (int i = 0; i < 4; i++) begin
            Adr      = comb_v[i].adr;
            Adr_Rmdr = comb_v[i].rm;
            #1;
            check($sformatf("comb_out_%0d", i), Out, comb_v[i].exp);
        end

        tick;
        rst = 1'b0;

        // Accept into an empty register while downstream is stalled
        Adr       = 26'h0000010;
        Adr_Rmdr  = 4'h2;
        in_valid  = 1'b1;
        tgt_ready = 1'b0;
        tick;
        check("hs_tgt", tgt, 32'h20000040);
        check("hs_tgt_valid", 32'(tgt_valid), 32'h1);
        check("hs_in_ready", 32'(in_ready), 32'h0);
        check("hs_cnt", 32'(jump_cnt), 32'h1);
`ifdef JUMP_SHIFT_ALIGN_CHECK_EN
        check("hs_misalign_first", 32'(misalign_err), 32'h0);
`endif

        // New input offered while stalled must be ignored
        Adr      = 26'h0000020;
        Adr_Rmdr = 4'h3;
        tick;
        check("stall_tgt", tgt, 32'h20000040);
        check("stall_tgt_valid", 32'(tgt_valid), 32'h1);
        check("stall_cnt", 32'(jump_cnt), 32'h1);

        // Asynchronous reset between edges with a pending target
        rst = 1'b1;
        #1;
        check("arst_tgt", tgt, 32'h0);
        check("arst_tgt_valid", 32'(tgt_valid), 32'h0);
        check("arst_cnt", 32'(jump_cnt), 32'h0);
        in_valid = 1'b0;
        tick;
        rst = 1'b0;

        // Back-to-back accepts with downstream always ready
        tgt_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            Adr      = b2b_v[i].adr;
            Adr_Rmdr = b2b_v[i].rm;
            tick;
            check($sformatf("b2b_tgt_%0d", i), tgt, b2b_v[i].exp);
            check($sformatf("b2b_valid_%0d", i), 32'(tgt_valid), 32'h1);
            check($sformatf("b2b_in_ready_%0d", i), 32'(in_ready), 32'h1);
        end
        check("b2b_cnt", 32'(jump_cnt), 32'h3);

        // Drain with nothing behind: valid drops, tgt holds
        in_valid = 1'b0;
        tick;
        check("drain_valid", 32'(tgt_valid), 32'h0);
        check("drain_tgt", tgt, 32'h20000C00);
        check("drain_cnt", 32'(jump_cnt), 32'h3);

        // Saturation of the 4-bit counter over 20 accepts
        rst = 1'b1;
        tick;
        rst = 1'b0;
        in_valid = 1'b1;
        exp_cnt  = 0;
        for (int i = 0; i < 20; i++) begin
            logic [3:0]  rm;
            logic [25:0] adr;
            rm  = 4'(i);
            adr = 26'(i * 3 + 1);
            Adr      = adr;
            Adr_Rmdr = rm;
            tick;
            if (exp_cnt < 15) exp_cnt++;
            check($sformatf("sat_tgt_%0d", i), tgt, {rm, adr, 2'b00});
            check($sformatf("sat_cnt_%0d", i), 32'(jump_cnt), 32'(exp_cnt));
        end
        check("sat_final", 32'(jump_cnt), 32'hF);

        // Region-crossing sequence: 1, 1, 3
        rst = 1'b1;
        in_valid = 1'b0;
        tick;
        rst = 1'b0;
        in_valid = 1'b1;
        Adr = 26'h0000005; Adr_Rmdr = 4'h1;
        tick;
        check("reg_tgt_0", tgt, 32'h10000014);
`ifdef JUMP_SHIFT_ALIGN_CHECK_EN
        check("reg_misalign_0", 32'(misalign_err), 32'h0);
`endif
        Adr = 26'h0000006; Adr_Rmdr = 4'h1;
        tick;
        check("reg_tgt_1", tgt, 32'h10000018);
`ifdef JUMP_SHIFT_ALIGN_CHECK_EN
        check("reg_misalign_1", 32'(misalign_err), 32'h0);
`endif
        Adr = 26'h0000007; Adr_Rmdr = 4'h3;
        tick;
        check("reg_tgt_2", tgt, 32'h3000001C);
`ifdef JUMP_SHIFT_ALIGN_CHECK_EN
        check("reg_misalign_2", 32'(misalign_err), 32'h1);
`endif
        check("reg_cnt", 32'(jump_cnt), 32'h3);
        in_valid = 1'b0;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
